// File: rtl/rx_pkg.sv
// Shared types and constants for the serial receiver.
// RX_PARITY_EN adds the PARITY state for 11-bit even-parity frames.
package rx_pkg;

  localparam int unsigned DATA_BITS = 8;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

`ifdef RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_e;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} rx_state_e;
`endif

endpackage

// File: rtl/rx_sample_counter.sv
// Mod-OVERSAMPLE sample counter with synchronous clear.
// The mid tick flags the centre of the start bit; the bit tick flags each wrap.
module rx_sample_counter #(
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic mid_tick_c,
  output logic bit_tick_c
);

  localparam int unsigned CW = $clog2(OVERSAMPLE);

  logic [CW-1:0] cnt;

  // Explicit wrap so non-power-of-two oversample ratios work.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear || bit_tick_c) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign mid_tick_c = (cnt == CW'(OVERSAMPLE / 2 - 1));
  assign bit_tick_c = (cnt == CW'(OVERSAMPLE - 1));

endmodule

// File: rtl/receiver.sv
// Oversampling asynchronous serial receiver: start, 8 data bits LSB first, stop.
// Define RX_PARITY_EN for an even-parity bit after data bit 7.
module receiver
  import rx_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 data_in,
  input  logic                 enable,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 character_received,
  output logic                 framing_error,
  output logic                 parity_error
);

  rx_state_e            state;
  logic                 sync1;
  logic                 rxs;
  logic                 rxs_d;
  logic [DATA_BITS-1:0] shift;
  logic [2:0]           bit_idx;
  logic                 fall_c;
  logic                 clear_c;
  logic                 mid_tick_c;
  logic                 bit_tick_c;
`ifdef RX_PARITY_EN
  logic                 par_err;
`endif

  // Two-flop synchronizer plus one stage of history for start-edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= IDLE_LEVEL;
      rxs   <= IDLE_LEVEL;
      rxs_d <= IDLE_LEVEL;
    end else begin
      sync1 <= data_in;
      rxs   <= sync1;
      rxs_d <= rxs;
    end
  end

  assign fall_c = (rxs_d == IDLE_LEVEL) && (rxs != IDLE_LEVEL);

  // Counter is parked in IDLE and re-phased at the start-bit centre so
  // every later bit tick lands mid-bit.
  assign clear_c = ((state == IDLE) && !(enable && fall_c)) ||
                   ((state == START) && mid_tick_c);

  rx_sample_counter #(
    .OVERSAMPLE (OVERSAMPLE)
  ) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear_c),
    .mid_tick_c (mid_tick_c),
    .bit_tick_c (bit_tick_c)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state              <= IDLE;
      shift              <= '0;
      bit_idx            <= '0;
      data_out           <= '0;
      character_received <= 1'b0;
      framing_error      <= 1'b0;
`ifdef RX_PARITY_EN
      parity_error       <= 1'b0;
      par_err            <= 1'b0;
`endif
    end else begin
      character_received <= 1'b0;
      framing_error      <= 1'b0;
`ifdef RX_PARITY_EN
      parity_error       <= 1'b0;
`endif
      if (!enable) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (fall_c) state <= START;
          end
          START: begin
            if (mid_tick_c) begin
              bit_idx <= '0;
              state   <= (rxs == START_BIT) ? DATA : IDLE;
            end
          end
          DATA: begin
            if (bit_tick_c) begin
              shift   <= {rxs, shift[DATA_BITS-1:1]};
              bit_idx <= bit_idx + 3'd1;
              if (bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end
            end
          end
`ifdef RX_PARITY_EN
          PARITY: begin
            if (bit_tick_c) begin
              par_err <= (rxs != ^shift);
              state   <= STOP;
            end
          end
`endif
          STOP: begin
            if (bit_tick_c) begin
              // Framing beats parity; a frame yields at most one strobe.
              if (rxs != STOP_BIT) begin
                framing_error <= 1'b1;
`ifdef RX_PARITY_EN
              end else if (par_err) begin
                parity_error <= 1'b1;
`endif
              end else begin
                data_out           <= shift;
                character_received <= 1'b1;
              end
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifndef RX_PARITY_EN
  assign parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_receiver.sv
// Self-checking bench for receiver: frame-level reference model with randomized traffic.
module tb_receiver;

  localparam int unsigned OS = 16;
`ifdef RX_PARITY_EN
  localparam bit          PARITY_ON  = 1'b1;
  localparam int unsigned FRAME_BITS = 11;
`else
  localparam bit          PARITY_ON  = 1'b0;
  localparam int unsigned FRAME_BITS = 10;
`endif
  // Strobe edge counted from the first edge that captures the start bit.
  localparam int N_LAT = 2 + OS / 2 + (FRAME_BITS - 1) * OS;

  localparam int K_CHAR = 1;
  localparam int K_FRM  = 2;
  localparam int K_PAR  = 3;

  logic       clk;
  logic       rst;
  logic       data_in;
  logic       enable;
  logic [7:0] data_out;
  logic       character_received;
  logic       framing_error;
  logic       parity_error;

  receiver #(.OVERSAMPLE(OS)) dut (
    .clk                (clk),
    .rst                (rst),
    .data_in            (data_in),
    .enable             (enable),
    .data_out           (data_out),
    .character_received (character_received),
    .framing_error      (framing_error),
    .parity_error       (parity_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         total = 0;
  int         bad = 0;
  logic [7:0] exp_dout;
  logic       par_flip = 1'b0;

  int         ev_kind[$];
  int         ev_cyc[$];
  logic [7:0] ev_dat[$];

  // Record every strobe with the edge number that produced it.
  always @(negedge clk) begin
    if (character_received === 1'b1) begin
      ev_kind.push_back(K_CHAR); ev_cyc.push_back(cyc); ev_dat.push_back(data_out);
    end
    if (framing_error === 1'b1) begin
      ev_kind.push_back(K_FRM); ev_cyc.push_back(cyc); ev_dat.push_back(data_out);
    end
    if (parity_error === 1'b1) begin
      ev_kind.push_back(K_PAR); ev_cyc.push_back(cyc); ev_dat.push_back(data_out);
    end
  end

  function automatic int exp_kind(input logic stop, input logic flip);
    if (!stop) return K_FRM;
    if (PARITY_ON && flip) return K_PAR;
    return K_CHAR;
  endfunction

  task automatic clear_events();
    ev_kind.delete(); ev_cyc.delete(); ev_dat.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic b);
    data_in = b;
    repeat (OS) @(negedge clk);
  endtask

  // Drive one whole frame; t0 is the edge that first captures the start bit.
  task automatic send_frame(input logic [7:0] d, input logic stop, output int t0);
    t0 = cyc + 1;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (PARITY_ON) drive_bit((^d) ^ par_flip);
    drive_bit(stop);
    data_in = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; data_in = 1'b1; enable = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (data_out !== 8'h00) begin bad++; $display("FAIL reset_data_out got=%h want=00", data_out); end
    total++; if (character_received !== 1'b0) begin bad++; $display("FAIL reset_char got=%b want=0", character_received); end
    total++; if (framing_error !== 1'b0) begin bad++; $display("FAIL reset_frm got=%b want=0", framing_error); end
    total++; if (parity_error !== 1'b0) begin bad++; $display("FAIL reset_par got=%b want=0", parity_error); end
    rst = 1'b1;
    exp_dout = 8'h00;
    idle(OS * 2);
    total++; if (ev_kind.size() != 0) begin bad++; $display("FAIL reset_idle_events got=%0d want=0", ev_kind.size()); end
    clear_events();
  endtask

  task automatic test_basic();
    int t0;
    clear_events();
    send_frame(8'hA5, 1'b1, t0);
    idle(8);
    exp_dout = 8'hA5;
    total++; if (ev_kind.size() != 1) begin bad++; $display("FAIL basic_count got=%0d want=1", ev_kind.size()); end
    else begin
      total++; if (ev_kind[0] != K_CHAR) begin bad++; $display("FAIL basic_kind got=%0d want=%0d", ev_kind[0], K_CHAR); end
      total++; if (ev_cyc[0] != t0 + N_LAT - 1) begin bad++; $display("FAIL basic_latency got=%0d want=%0d", ev_cyc[0] - t0 + 1, N_LAT); end
      total++; if (ev_dat[0] !== 8'hA5) begin bad++; $display("FAIL basic_data got=%h want=a5", ev_dat[0]); end
    end
    total++; if (data_out !== exp_dout) begin bad++; $display("FAIL basic_hold got=%h want=%h", data_out, exp_dout); end
  endtask

  task automatic test_random();
    int t0;
    logic [7:0] d;
    logic stop;
    int k;
    for (int it = 0; it < 10; it++) begin
      d = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      par_flip = PARITY_ON ? 1'($urandom_range(0, 1)) : 1'b0;
      k = exp_kind(stop, par_flip);
      clear_events();
      idle($urandom_range(1, 30));
      send_frame(d, stop, t0);
      idle(8);
      if (k == K_CHAR) exp_dout = d;
      total++; if (ev_kind.size() != 1) begin bad++; $display("FAIL rand%0d_count got=%0d want=1 byte=%h", it, ev_kind.size(), d); end
      else begin
        total++; if (ev_kind[0] != k) begin bad++; $display("FAIL rand%0d_kind got=%0d want=%0d byte=%h", it, ev_kind[0], k, d); end
        total++; if (ev_cyc[0] != t0 + N_LAT - 1) begin bad++; $display("FAIL rand%0d_latency got=%0d want=%0d", it, ev_cyc[0] - t0 + 1, N_LAT); end
      end
      total++; if (data_out !== exp_dout) begin bad++; $display("FAIL rand%0d_data got=%h want=%h", it, data_out, exp_dout); end
    end
    par_flip = 1'b0;
  endtask

  task automatic test_glitch();
    clear_events();
    data_in = 1'b0;
    idle(4);
    data_in = 1'b1;
    idle(OS * 12);
    total++; if (ev_kind.size() != 0) begin bad++; $display("FAIL glitch_events got=%0d want=0", ev_kind.size()); end
    total++; if (data_out !== exp_dout) begin bad++; $display("FAIL glitch_data got=%h want=%h", data_out, exp_dout); end
  endtask

  task automatic test_framing();
    int t0;
    clear_events();
    send_frame(8'h3C, 1'b0, t0);
    idle(8);
    total++; if (ev_kind.size() != 1) begin bad++; $display("FAIL frm_count got=%0d want=1", ev_kind.size()); end
    else begin
      total++; if (ev_kind[0] != K_FRM) begin bad++; $display("FAIL frm_kind got=%0d want=%0d", ev_kind[0], K_FRM); end
      total++; if (ev_cyc[0] != t0 + N_LAT - 1) begin bad++; $display("FAIL frm_latency got=%0d want=%0d", ev_cyc[0] - t0 + 1, N_LAT); end
    end
    total++; if (data_out !== exp_dout) begin bad++; $display("FAIL frm_data got=%h want=%h", data_out, exp_dout); end
  endtask

  task automatic test_break();
    int t0;
    clear_events();
    t0 = cyc + 1;
    data_in = 1'b0;
    idle(OS * 30);
    data_in = 1'b1;
    idle(OS * 4);
    total++; if (ev_kind.size() != 1) begin bad++; $display("FAIL break_count got=%0d want=1", ev_kind.size()); end
    else begin
      total++; if (ev_kind[0] != K_FRM) begin bad++; $display("FAIL break_kind got=%0d want=%0d", ev_kind[0], K_FRM); end
      total++; if (ev_cyc[0] != t0 + N_LAT - 1) begin bad++; $display("FAIL break_latency got=%0d want=%0d", ev_cyc[0] - t0 + 1, N_LAT); end
    end
    total++; if (data_out !== exp_dout) begin bad++; $display("FAIL break_data got=%h want=%h", data_out, exp_dout); end
  endtask

  task automatic test_back_to_back();
    int t0;
    int t1;
    clear_events();
    send_frame(8'h00, 1'b1, t0);
    send_frame(8'hFF, 1'b1, t1);
    idle(8);
    exp_dout = 8'hFF;
    total++; if (ev_kind.size() != 2) begin bad++; $display("FAIL b2b_count got=%0d want=2", ev_kind.size()); end
    else begin
      total++; if (ev_kind[0] != K_CHAR || ev_kind[1] != K_CHAR) begin bad++; $display("FAIL b2b_kind got=%0d,%0d want=%0d,%0d", ev_kind[0], ev_kind[1], K_CHAR, K_CHAR); end
      total++; if (ev_dat[0] !== 8'h00) begin bad++; $display("FAIL b2b_first got=%h want=00", ev_dat[0]); end
      total++; if (ev_dat[1] !== 8'hFF) begin bad++; $display("FAIL b2b_second got=%h want=ff", ev_dat[1]); end
      total++; if (ev_cyc[0] != t0 + N_LAT - 1) begin bad++; $display("FAIL b2b_latency got=%0d want=%0d", ev_cyc[0] - t0 + 1, N_LAT); end
      total++; if (ev_cyc[1] - ev_cyc[0] != int'(FRAME_BITS * OS)) begin bad++; $display("FAIL b2b_spacing got=%0d want=%0d", ev_cyc[1] - ev_cyc[0], FRAME_BITS * OS); end
    end
  endtask

  task automatic test_disabled();
    int t0;
    clear_events();
    enable = 1'b0;
    send_frame(8'h5A, 1'b1, t0);
    idle(8);
    enable = 1'b1;
    idle(OS);
    total++; if (ev_kind.size() != 0) begin bad++; $display("FAIL disabled_events got=%0d want=0", ev_kind.size()); end
    total++; if (data_out !== exp_dout) begin bad++; $display("FAIL disabled_data got=%h want=%h", data_out, exp_dout); end
  endtask

  task automatic send_81_and_check(input string tag);
    int t0;
    clear_events();
    send_frame(8'h81, 1'b1, t0);
    idle(8);
    exp_dout = 8'h81;
    total++; if (ev_kind.size() != 1) begin bad++; $display("FAIL %s_resume_count got=%0d want=1", tag, ev_kind.size()); end
    else begin
      total++; if (ev_cyc[0] != t0 + N_LAT - 1) begin bad++; $display("FAIL %s_resume_latency got=%0d want=%0d", tag, ev_cyc[0] - t0 + 1, N_LAT); end
    end
    total++; if (data_out !== 8'h81) begin bad++; $display("FAIL %s_resume_data got=%h want=81", tag, data_out); end
  endtask

  task automatic test_abort_enable();
    logic [7:0] d = 8'h55;
    clear_events();
    data_in = 1'b0; idle(OS);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    enable = 1'b0;
    data_in = 1'b1;
    idle(3);
    enable = 1'b1;
    idle(OS * 12);
    total++; if (ev_kind.size() != 0) begin bad++; $display("FAIL abort_en_events got=%0d want=0", ev_kind.size()); end
    total++; if (data_out !== exp_dout) begin bad++; $display("FAIL abort_en_data got=%h want=%h", data_out, exp_dout); end
    send_81_and_check("abort_en");
  endtask

  task automatic test_abort_reset();
    logic [7:0] d = 8'h55;
    clear_events();
    data_in = 1'b0; idle(OS);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    #1 rst = 1'b0;
    #1;
    total++; if (data_out !== 8'h00) begin bad++; $display("FAIL abort_rst_async got=%h want=00", data_out); end
    exp_dout = 8'h00;
    data_in = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    idle(OS * 12);
    total++; if (ev_kind.size() != 0) begin bad++; $display("FAIL abort_rst_events got=%0d want=0", ev_kind.size()); end
    total++; if (data_out !== exp_dout) begin bad++; $display("FAIL abort_rst_data got=%h want=%h", data_out, exp_dout); end
    send_81_and_check("abort_rst");
  endtask

`ifdef RX_PARITY_EN
  task automatic test_parity();
    int t0;
    clear_events();
    par_flip = 1'b1;
    send_frame(8'h07, 1'b1, t0);
    idle(8);
    total++; if (ev_kind.size() != 1) begin bad++; $display("FAIL par_bad_count got=%0d want=1", ev_kind.size()); end
    else begin
      total++; if (ev_kind[0] != K_PAR) begin bad++; $display("FAIL par_bad_kind got=%0d want=%0d", ev_kind[0], K_PAR); end
    end
    total++; if (data_out !== exp_dout) begin bad++; $display("FAIL par_bad_data got=%h want=%h", data_out, exp_dout); end
    clear_events();
    par_flip = 1'b0;
    send_frame(8'h07, 1'b1, t0);
    idle(8);
    exp_dout = 8'h07;
    total++; if (ev_kind.size() != 1) begin bad++; $display("FAIL par_ok_count got=%0d want=1", ev_kind.size()); end
    else begin
      total++; if (ev_kind[0] != K_CHAR) begin bad++; $display("FAIL par_ok_kind got=%0d want=%0d", ev_kind[0], K_CHAR); end
    end
    total++; if (data_out !== 8'h07) begin bad++; $display("FAIL par_ok_data got=%h want=07", data_out); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_framing();
    test_back_to_back();
    test_abort_enable();
    test_abort_reset();
    test_disabled();
    test_break();
`ifdef RX_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
